apb_master_q: RTL and testbench

//  Parametrised APB (AMBA3/APB4) master with a command queue and response channel.

---
 rtl/apb_master_q.sv | 175 +++++++++++++++++
 tb/tb_apb_master_q.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_q.sv
// APB master with an in-order command FIFO and a registered per-transfer response channel.
// Optional ACCESS-phase timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_q #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  trf_valid,
  output logic                  trf_ready,
  input  logic                  trf_write,
  input  logic [ADDR_W-1:0]     trf_addr,
  input  logic [DATA_W-1:0]     trf_wdata,
  input  logic [DATA_W/8-1:0]   trf_strb,
  output logic                  trf_rsp_valid,
  output logic                  trf_rsp_write,
  output logic                  trf_rsp_err,
  output logic [DATA_W-1:0]     trf_rdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W  = $clog2(CMD_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_nxt;

  logic              write_mem [CMD_DEPTH];
  logic [ADDR_W-1:0] addr_mem  [CMD_DEPTH];
  logic [DATA_W-1:0] wdata_mem [CMD_DEPTH];
  logic [STRB_W-1:0] strb_mem  [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, empty, full;
  logic             xfer_done, timeout;

  assign full      = (count == CNT_W'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign trf_ready = ~full;
  assign push      = trf_valid & trf_ready;

  // Command storage carries data only; no reset needed.
  always_ff @(posedge pclk) begin
    if (push) begin
      write_mem[wr_ptr] <= trf_write;
      addr_mem[wr_ptr]  <= trf_addr;
      wdata_mem[wr_ptr] <= trf_wdata;
      strb_mem[wr_ptr]  <= trf_write ? trf_strb : '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Cleared while in SETUP so each transfer starts ACCESS with a fresh count.
  always_ff @(posedge pclk) begin
    if (prst) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign timeout = (state == ACCESS) && !pready && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  assign xfer_done = (state == ACCESS) && (pready || timeout);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = SETUP;
          pop       = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready || timeout) begin
          if (!empty) begin
            state_nxt = SETUP;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
    end else begin
      state   <= state_nxt;
      psel    <= (state_nxt != IDLE);
      penable <= (state_nxt == ACCESS);
      if (pop) begin
        pwrite <= write_mem[rd_ptr];
        paddr  <= addr_mem[rd_ptr];
        pwdata <= wdata_mem[rd_ptr];
        pstrb  <= strb_mem[rd_ptr];
      end
    end
  end

  // A completion without pready can only be a timeout, which reports as an error.
  always_ff @(posedge pclk) begin
    if (prst) begin
      trf_rsp_valid <= 1'b0;
      trf_rsp_write <= 1'b0;
      trf_rsp_err   <= 1'b0;
      trf_rdata     <= '0;
    end else begin
      trf_rsp_valid <= xfer_done;
      if (xfer_done) begin
        trf_rsp_write <= pwrite;
        trf_rsp_err   <= ~pready | pslverr;
        trf_rdata     <= (pready && !pwrite && !pslverr) ? prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_q.sv
// Randomized bench for apb_master_q: a queue-based transaction model predicts APB
// phase sequence, issued command fields, FIFO readiness and every response.
module tb_apb_master_q;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int SW          = DATA_W / 8;
  localparam int CMD_DEPTH   = 4;
  localparam int TIMEOUT_CYC = 16;

  logic              pclk = 1'b0;
  logic              prst;
  logic              trf_valid, trf_ready, trf_write;
  logic [ADDR_W-1:0] trf_addr;
  logic [DATA_W-1:0] trf_wdata;
  logic [SW-1:0]     trf_strb;
  logic              trf_rsp_valid, trf_rsp_write, trf_rsp_err;
  logic [DATA_W-1:0] trf_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [SW-1:0]     pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;

  apb_master_q #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .pclk(pclk), .prst(prst),
    .trf_valid(trf_valid), .trf_ready(trf_ready), .trf_write(trf_write),
    .trf_addr(trf_addr), .trf_wdata(trf_wdata), .trf_strb(trf_strb),
    .trf_rsp_valid(trf_rsp_valid), .trf_rsp_write(trf_rsp_write),
    .trf_rsp_err(trf_rsp_err), .trf_rdata(trf_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [SW-1:0]     s;
  } cmd_t;

  typedef struct packed {
    logic              w;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;
  int rdy_pct = 100;
  int err_pct = 0;
  bit fix_en = 0;
  logic [DATA_W-1:0] fix_data = '0;

  cmd_t q_pend[$];
  cmd_t cur;
  rsp_t exp_rsp, last_rsp;
  bit   armed = 0;
  bit   rst_chk = 0;
  bit   rsp_due = 0;
  logic [1:0] exp_st = 2'b00;
  int   acc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural APB slave: random wait states, errors and read data.
  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(posedge pclk);
      #2;
      pready  = ($urandom_range(99) < rdy_pct);
      pslverr = ($urandom_range(99) < err_pct);
      prdata  = fix_en ? fix_data : DATA_W'($urandom);
    end
  end

  // Transaction model, evaluated mid-cycle with all inputs stable.
  always @(negedge pclk) begin
    logic [1:0] st;
    logic       pend, done, tmo;
    rsp_t       want;
    st = {psel, penable};
    if (prst) begin
      armed = 1; q_pend.delete(); exp_st = 2'b00; rsp_due = 0;
      last_rsp = '0; rst_chk = 1; acc_n = 0;
    end else if (armed) begin
      if (rst_chk) begin
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_ready", trf_ready, 1);
        rst_chk = 0;
      end
      chk("apb_phase", st, exp_st);
      chk("rsp_valid", trf_rsp_valid, rsp_due);
      want = rsp_due ? exp_rsp : last_rsp;
      chk("rsp_write", trf_rsp_write, want.w);
      chk("rsp_err", trf_rsp_err, want.err);
      chk("rsp_rdata", trf_rdata, want.rdata);
      if (trf_rsp_valid) n_rsp++;
      last_rsp = want;
      if (st == 2'b10) begin
        chk("setup_has_cmd", q_pend.size() != 0, 1);
        if (q_pend.size() != 0) cur = q_pend.pop_front();
        acc_n = 0;
      end
      if (st[1]) begin
        chk("paddr", paddr, cur.a);
        chk("pwrite", pwrite, cur.w);
        chk("pwdata", pwdata, cur.d);
        chk("pstrb", pstrb, cur.w ? cur.s : '0);
      end
      chk("trf_ready", trf_ready, q_pend.size() < CMD_DEPTH);
      pend = (q_pend.size() != 0);
      done = 0;
      tmo  = 0;
      if (st == 2'b11) begin
`ifdef APB_MASTER_TIMEOUT_EN
        tmo = !pready && (acc_n == TIMEOUT_CYC - 1);
`endif
        if (pready) begin
          exp_rsp.w     = cur.w;
          exp_rsp.err   = pslverr;
          exp_rsp.rdata = (!cur.w && !pslverr) ? prdata : '0;
          done = 1;
        end else if (tmo) begin
          exp_rsp.w     = cur.w;
          exp_rsp.err   = 1'b1;
          exp_rsp.rdata = '0;
          done = 1;
        end
        acc_n++;
      end
      rsp_due = done;
      case (st)
        2'b00:   exp_st = pend ? 2'b10 : 2'b00;
        2'b10:   exp_st = 2'b11;
        2'b11:   exp_st = done ? (pend ? 2'b10 : 2'b00) : 2'b11;
        default: exp_st = 2'b00;
      endcase
      if (trf_valid && trf_ready) q_pend.push_back({trf_write, trf_addr, trf_wdata, trf_strb});
    end
  end

  // Entered and left at posedge+1.
  task automatic push(input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
    bit ok;
    ok = 0;
    trf_valid = 1'b1; trf_write = w; trf_addr = a; trf_wdata = d; trf_strb = s;
    for (int k = 0; k < 300; k++) begin
      @(negedge pclk);
      if (trf_ready) begin
        ok = 1;
        break;
      end
    end
    chk("push_accepted", ok, 1);
    @(posedge pclk); #1;
    trf_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 600; k++) begin
      @(negedge pclk);
      if (q_pend.size() == 0 && !psel && !rsp_due) break;
    end
    chk("drain_done", (q_pend.size() == 0) && !psel, 1);
    @(posedge pclk); #1;
  endtask

  task automatic wait_access(output bit seen);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (penable) begin
        seen = 1;
        break;
      end
    end
    chk("reach_access", seen, 1);
  endtask

  initial begin
    int  n0, cyc;
    bit  seen;
    prst = 1'b1;
    trf_valid = 1'b0; trf_write = 1'b0; trf_addr = '0; trf_wdata = '0; trf_strb = '0;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;
    @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", trf_rsp_valid, 0);
    @(posedge pclk); #1;

    // Single write with immediate pready: exact latency.
    rdy_pct = 100;
    push(1'b1, 8'h3C, 8'hA5, 1'b1);
    @(negedge pclk);
    chk("t1_idle_psel", psel, 0);
    @(negedge pclk);
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_penable", penable, 0);
    @(negedge pclk);
    chk("t1_access_penable", penable, 1);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_pwdata", pwdata, 8'hA5);
    @(negedge pclk);
    chk("t1_rsp_valid", trf_rsp_valid, 1);
    chk("t1_rsp_err", trf_rsp_err, 0);
    chk("t1_rsp_rdata", trf_rdata, 0);
    drain();

    // Read with three wait states.
    rdy_pct = 0; fix_en = 1; fix_data = 8'h5A; n0 = n_rsp;
    push(1'b0, 8'h10, 8'h00, 1'b1);
    wait_access(seen);
    repeat (2) @(negedge pclk);
    @(posedge pclk); #1;
    rdy_pct = 100;
    @(negedge pclk);
    @(negedge pclk);
    chk("t2_rsp_valid", trf_rsp_valid, 1);
    chk("t2_rdata", trf_rdata, 8'h5A);
    drain();
    chk("t2_rsp_count", n_rsp - n0, 1);
    fix_en = 0;

    // Fill the queue while the slave stalls, then release.
    rdy_pct = 0; n0 = n_rsp;
    for (int i = 0; i < 5; i++) push(i[0], ADDR_W'(8'h40 + i), DATA_W'(8'h11 * i), 1'b1);
    @(negedge pclk);
    chk("t3_ready_full", trf_ready, 0);
    @(posedge pclk); #1;
    rdy_pct = 100;
    drain();
    chk("t3_rsp_count", n_rsp - n0, 5);

    // Slave error on a read, followed by a queued write.
    err_pct = 100; fix_en = 1; fix_data = 8'hFF;
    push(1'b0, 8'h20, 8'h00, 1'b1);
    push(1'b1, 8'h21, 8'h77, 1'b1);
    drain();
    chk("t4_hold_err", trf_rsp_err, 1);
    chk("t4_hold_rdata", trf_rdata, 0);
    err_pct = 0; fix_en = 0;

    // Reset in the middle of ACCESS with commands queued.
    rdy_pct = 0;
    for (int i = 0; i < 3; i++) push(1'b1, ADDR_W'(8'h60 + i), 8'hC3, 1'b1);
    wait_access(seen);
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0;
    n0 = n_rsp;
    rdy_pct = 100;
    repeat (5) @(negedge pclk);
    chk("t5_psel", psel, 0);
    chk("t5_no_rsp", n_rsp - n0, 0);
    @(posedge pclk); #1;

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never answers: abort after TIMEOUT_CYC ACCESS cycles.
    rdy_pct = 0; n0 = n_rsp;
    push(1'b0, 8'h33, 8'h00, 1'b1);
    wait_access(seen);
    cyc = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (!penable) break;
      cyc++;
    end
    chk("t6_access_cycles", cyc, TIMEOUT_CYC);
    chk("t6_psel", psel, 0);
    chk("t6_rsp_valid", trf_rsp_valid, 1);
    chk("t6_rsp_err", trf_rsp_err, 1);
    chk("t6_rsp_rdata", trf_rdata, 0);
    @(posedge pclk); #1;
    rdy_pct = 100;
`endif

    // Randomized traffic.
    rdy_pct = 60; err_pct = 20; n0 = n_rsp;
    cyc = 0;
    for (int i = 0; i < 250; i++) begin
      push(1'($urandom_range(1)), ADDR_W'($urandom), DATA_W'($urandom), SW'($urandom));
      cyc++;
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3)) begin
          @(posedge pclk); #1;
        end
      end
    end
    rdy_pct = 100;
    drain();
    chk("rand_rsp_count", n_rsp - n0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
